// File: rtl/spi_ram_pkg.sv
// Shared FSM state encoding, SPI command codes and a width helper for the SPI RAM slave.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_TURN,
    RD_DATA,
    HOLD
  } state_t;

  localparam logic [2:0] CMD_WR_ADDR = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_ADDR = 3'b110;
  localparam logic [2:0] CMD_RD_TURN = 3'b111;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// Contents are deliberately not reset.
module spi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_slave_ram_p.sv
// SPI-framed RAM slave: 3-bit command then address/data payload, MSB first, sampled on clk.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each completed data frame.
import spi_ram_pkg::*;

module spi_slave_ram_p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic cmd_err
);

  // Shift register must also hold the 3-bit command.
  localparam int MAX_W = max2(max2(ADDR_W, DATA_W), 3);
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [MAX_W-2:0]  r_shift;
  logic [MAX_W-1:0]  w_shift_in;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_rd_sh, w_rdata;
  logic              r_miso, r_cmd_err;
  logic              w_we, w_re, w_cmd_err;

  assign w_shift_in = {r_shift, MOSI};

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_cmd_err = 1'b0;
    case (r_state)
      IDLE:    if (!SS_n) w_next = CMD;
      CMD: begin
        if (r_cnt == CMD_LAST) begin
          case (w_shift_in[2:0])
            CMD_WR_ADDR: w_next = WR_ADDR;
            CMD_WR_DATA: w_next = WR_DATA;
            CMD_RD_ADDR: w_next = RD_ADDR;
            CMD_RD_TURN: w_next = RD_TURN;
            default: begin
              w_next    = HOLD;
              w_cmd_err = 1'b1;
            end
          endcase
        end
      end
      WR_ADDR, RD_ADDR: if (r_cnt == ADDR_LAST) w_next = HOLD;
      WR_DATA: begin
        if (r_cnt == DATA_LAST) begin
          w_next = HOLD;
          w_we   = 1'b1;
        end
      end
      RD_TURN: begin
        w_next = RD_DATA;
        w_re   = 1'b1;
      end
      // One extra edge after the LSB so MISO returns to 0 while still in RD_DATA.
      RD_DATA: if (r_cnt == DATA_END) w_next = HOLD;
      HOLD:    w_next = r_state;
      default: w_next = IDLE;
    endcase
    if (SS_n) begin
      w_next    = IDLE;
      w_we      = 1'b0;
      w_re      = 1'b0;
      w_cmd_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_rd_sh   <= '0;
      r_miso    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cmd_err <= w_cmd_err;
      r_miso    <= 1'b0;
      if (w_next != r_state) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_shift <= w_shift_in[MAX_W-2:0];
      end
      if (r_state == RD_DATA && w_next == RD_DATA) begin
        r_miso  <= (r_cnt == '0) ? w_rdata[DATA_W-1] : r_rd_sh[DATA_W-1];
        r_rd_sh <= ((r_cnt == '0) ? w_rdata : r_rd_sh) << 1;
      end
      if (r_state == WR_ADDR && w_next == HOLD) r_wr_addr <= w_shift_in[ADDR_W-1:0];
      if (r_state == RD_ADDR && w_next == HOLD) r_rd_addr <= w_shift_in[ADDR_W-1:0];
`ifdef SPI_RAM_AUTOINC_EN
      if (w_we) r_wr_addr <= r_wr_addr + ADDR_W'(1);
      if (r_state == RD_DATA && w_next == HOLD) r_rd_addr <= r_rd_addr + ADDR_W'(1);
`endif
    end
  end

  spi_ram_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_wr_addr),
    .i_wdata(w_shift_in[DATA_W-1:0]),
    .i_re   (w_re),
    .i_raddr(r_rd_addr),
    .o_rdata(w_rdata)
  );

  assign MISO    = r_miso;
  assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_spi_slave_ram_p.sv
// Directed bench for spi_slave_ram_p: an 8/8 instance and a 4/16 instance share clk/rst/SS_n/MOSI.
module tb_spi_slave_ram_p;

  logic clk = 1'b0;
  logic rst, SS_n, MOSI;
  logic miso_a, err_a, miso_b, err_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spi_slave_ram_p #(.ADDR_W(8), .DATA_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_a), .cmd_err(err_a)
  );

  spi_slave_ram_p #(.ADDR_W(4), .DATA_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_b), .cmd_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic miso_of(input int which);
    return (which != 0) ? miso_b : miso_a;
  endfunction

  function automatic logic err_of(input int which);
    return (which != 0) ? err_b : err_a;
  endfunction

  task automatic frame(input logic [2:0] cmd, input logic [15:0] pl, input int n);
    SS_n = 1'b0; MOSI = 1'b0; tick();
    for (int i = 2; i >= 0; i--) begin MOSI = cmd[i]; tick(); end
    for (int i = n - 1; i >= 0; i--) begin MOSI = pl[i]; tick(); end
    SS_n = 1'b1; MOSI = 1'b0; tick();
  endtask

  // Read-data frame; E is the edge sampling the last command bit.
  task automatic rd(input int dw, input int which, input logic [31:0] exp, input string tag);
    logic [31:0] word;
    SS_n = 1'b0; MOSI = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin MOSI = 1'b1; tick(); end
    chk("cmd_err_legal", {31'd0, err_of(which)}, 32'd0);
    MOSI = 1'b0; tick();
    chk("miso_before_data", {31'd0, miso_of(which)}, 32'd0);
    word = 32'd0;
    for (int k = 0; k < dw; k++) begin
      tick();
      word = {word[30:0], miso_of(which)};
    end
    chk(tag, word, exp);
    tick();
    chk("miso_after_data", {31'd0, miso_of(which)}, 32'd0);
    SS_n = 1'b1; tick();
  endtask

  task automatic illegal_cmd(input logic [2:0] cmd, input string tag);
    logic acc;
    SS_n = 1'b0; MOSI = 1'b0; tick();
    for (int i = 2; i >= 0; i--) begin MOSI = cmd[i]; tick(); end
    chk(tag, {31'd0, err_a}, 32'd1);
    chk("cmd_err_b", {31'd0, err_b}, 32'd1);
    chk("miso_on_err", {31'd0, miso_a}, 32'd0);
    acc = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      MOSI = (i % 3 != 0);
      tick();
      acc = acc | err_a | miso_a;
    end
    chk("hold_quiet", {31'd0, acc}, 32'd0);
    SS_n = 1'b1; MOSI = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso_a}, 32'd0);
    chk("rst_cmd_err", {31'd0, err_a}, 32'd0);
    chk("rst_miso_b", {31'd0, miso_b}, 32'd0);
    rst = 1'b0;
    tick();

    // Write-data with reset wr_addr=0, then read-data with reset rd_addr=0.
    frame(3'b001, 16'h96, 8);
    rd(8, 0, 32'h96, "rd_addr_default0");

    frame(3'b000, 16'h05, 8);
    frame(3'b001, 16'hFF, 8);
    frame(3'b110, 16'h05, 8);
    rd(8, 0, 32'hFF, "read_ff_at_05");

    frame(3'b000, 16'h10, 8);
    frame(3'b001, 16'h1E, 8);
    frame(3'b000, 16'h11, 8);
    frame(3'b001, 16'hC5, 8);
    frame(3'b110, 16'h10, 8);
    rd(8, 0, 32'h1E, "read_1e_at_10");
    frame(3'b110, 16'h11, 8);
    rd(8, 0, 32'hC5, "read_c5_at_11");

    // Aborted write-data after 4 bits of 0x3C.
    frame(3'b000, 16'h20, 8);
    frame(3'b001, 16'h11, 8);
    frame(3'b001, 16'h3, 4);
    frame(3'b110, 16'h20, 8);
    rd(8, 0, 32'h11, "abort_no_write");
    frame(3'b001, 16'h6B, 8);
`ifdef SPI_RAM_AUTOINC_EN
    frame(3'b110, 16'h21, 8);
`else
    frame(3'b110, 16'h20, 8);
`endif
    rd(8, 0, 32'h6B, "abort_keeps_wr_addr");

    illegal_cmd(3'b010, "cmd_err_010");
    illegal_cmd(3'b100, "cmd_err_100");
    frame(3'b110, 16'h10, 8);
    rd(8, 0, 32'h1E, "illegal_no_change");

    // Reset mid RD_DATA of 0xFF at address 5.
    frame(3'b110, 16'h05, 8);
    SS_n = 1'b0; MOSI = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin MOSI = 1'b1; tick(); end
    MOSI = 1'b0;
    repeat (4) tick();
    chk("miso_mid_read", {31'd0, miso_a}, 32'd1);
    #1 rst = 1'b1;
    #1 chk("miso_async_rst", {31'd0, miso_a}, 32'd0);
    SS_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    rd(8, 0, 32'h96, "post_rst_addr0");

    // Reset before the last write-data bit cancels the write.
    frame(3'b000, 16'h00, 8);
    SS_n = 1'b0; MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    MOSI = 1'b1; tick();
    for (int i = 7; i >= 1; i--) begin MOSI = (8'h5A >> i) & 1'b1; tick(); end
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    frame(3'b110, 16'h00, 8);
    rd(8, 0, 32'h96, "rst_cancels_write");

    frame(3'b000, 16'hFF, 8);
    frame(3'b001, 16'hAA, 8);
    frame(3'b001, 16'h55, 8);
    frame(3'b110, 16'hFF, 8);
`ifdef SPI_RAM_AUTOINC_EN
    rd(8, 0, 32'hAA, "wrap_mem_ff");
    frame(3'b110, 16'h00, 8);
    rd(8, 0, 32'h55, "wrap_mem_00");
    frame(3'b110, 16'hFF, 8);
    rd(8, 0, 32'hAA, "rd_wrap_first");
    rd(8, 0, 32'h55, "rd_wrap_second");
`else
    rd(8, 0, 32'h55, "wrap_mem_ff");
    frame(3'b110, 16'h00, 8);
    rd(8, 0, 32'h96, "wrap_mem_00");
    frame(3'b110, 16'hFF, 8);
    rd(8, 0, 32'h55, "rd_wrap_first");
    rd(8, 0, 32'h55, "rd_wrap_second");
`endif

    // 4-bit address / 16-bit data instance.
    frame(3'b000, 16'h000F, 4);
    frame(3'b001, 16'hBEEF, 16);
    frame(3'b110, 16'h000F, 4);
    rd(16, 1, 32'hBEEF, "wide_read_beef");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
